// File: rtl/key_sw_io_device.sv
// Memory-mapped KEY/SW input responder: two-flop synchronizers, whole-vector
// debounce, data/ctrl registers with ready/overrun status and interrupt requests.

module key_sw_debounce #(
  parameter int W               = 4,
  parameter bit INVERT          = 1'b0,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_BITS        = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] rawIn,
  output logic [W-1:0] data,
  output logic         changeEvent
);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(DEBOUNCE_CYCLES);
  localparam logic [CNT_BITS-1:0] CNT_FIRE = CNT_BITS'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  logic [W-1:0]        sync1;
  logic [W-1:0]        sync2;
  logic [W-1:0]        sample;
  logic [W-1:0]        prevSample;
  logic [W-1:0]        dataReg;
  logic [CNT_BITS-1:0] cnt;
  logic                stable;

  assign sample = INVERT ? ~sync2 : sync2;
  assign stable = (sample == prevSample);
  // Fires on the edge where the counter reaches the threshold (or holds there).
  assign changeEvent = stable && (cnt >= CNT_FIRE) && (sample != dataReg);
  assign data = dataReg;

  // Synchronizer, stability counter and debounced data register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= '0;
      sync2      <= '0;
      prevSample <= '0;
      cnt        <= '0;
      dataReg    <= '0;
    end else begin
      sync1      <= rawIn;
      sync2      <= sync1;
      prevSample <= sample;
      if (!stable) begin
        cnt <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end else begin
        cnt <= cnt;
      end
      if (changeEvent) begin
        dataReg <= sample;
      end else begin
        dataReg <= dataReg;
      end
    end
  end
endmodule

module key_sw_io_device #(
  parameter logic [31:0] ADDR_KDATA      = 32'hF000_0010,
  parameter logic [31:0] ADDR_SDATA      = 32'hF000_0014,
  parameter logic [31:0] ADDR_KCTRL      = 32'hF000_0110,
  parameter logic [31:0] ADDR_SCTRL      = 32'hF000_0114,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          CNT_BITS        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wrData,
  input  logic        isLoad,
  input  logic        isStore,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  output logic [31:0] rdData,
  output logic        hit,
  output logic        kIntr,
  output logic        sIntr
);
  logic [3:0] kData;
  logic [9:0] sData;
  logic       kEvt, sEvt;
  logic       kReady, kOvr, kIe;
  logic       sReady, sOvr, sIe;
  logic [2:0] kNext, sNext;
  logic       loadOp;
  logic       kClrReady, sClrReady, kClrOvr, sClrOvr, kWrIe, sWrIe;
  logic       unusedWr;

  key_sw_debounce #(.W(4), .INVERT(1'b1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_BITS(CNT_BITS))
    kDeb (.clk(clk), .reset(reset), .rawIn(KEY), .data(kData), .changeEvent(kEvt));
  key_sw_debounce #(.W(10), .INVERT(1'b0), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_BITS(CNT_BITS))
    sDeb (.clk(clk), .reset(reset), .rawIn(SW), .data(sData), .changeEvent(sEvt));

  // A store wins over a simultaneous (illegal) load.
  assign loadOp    = isLoad & ~isStore;
  assign kWrIe     = isStore & (addr == ADDR_KCTRL);
  assign sWrIe     = isStore & (addr == ADDR_SCTRL);
  assign kClrReady = (loadOp & (addr == ADDR_KDATA)) | (kWrIe & ~wrData[0]);
  assign sClrReady = (loadOp & (addr == ADDR_SDATA)) | (sWrIe & ~wrData[0]);
  assign kClrOvr   = kWrIe & ~wrData[2];
  assign sClrOvr   = sWrIe & ~wrData[2];
  assign unusedWr  = ^{wrData[31:9], wrData[7:3], wrData[1]};

  // Returns {ie, overrun, ready}; a change event beats any ready clear.
  function automatic logic [2:0] ctrlNext(input logic ready, input logic ovr, input logic ie,
                                          input logic evt, input logic clrReady,
                                          input logic clrOvr, input logic wrIe, input logic newIe);
    logic rdyN, ovrN, ieN;
    if (evt) begin
      rdyN = 1'b1;
      ovrN = (ready & ~clrReady) | (ovr & ~clrOvr);
    end else begin
      rdyN = ready & ~clrReady;
      ovrN = ovr & ~clrOvr;
    end
    ieN = wrIe ? newIe : ie;
    return {ieN, ovrN, rdyN};
  endfunction

  // Next-state for both control registers
  always_comb begin
    kNext = ctrlNext(kReady, kOvr, kIe, kEvt, kClrReady, kClrOvr, kWrIe, wrData[8]);
    sNext = ctrlNext(sReady, sOvr, sIe, sEvt, sClrReady, sClrOvr, sWrIe, wrData[8]);
  end

  // Control registers and registered interrupt requests
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {kIe, kOvr, kReady} <= 3'b000;
      {sIe, sOvr, sReady} <= 3'b000;
      kIntr               <= 1'b0;
      sIntr               <= 1'b0;
    end else begin
      {kIe, kOvr, kReady} <= kNext;
      {sIe, sOvr, sReady} <= sNext;
      kIntr               <= kReady & kIe;
      sIntr               <= sReady & sIe;
    end
  end

  // Combinational read mux and address decode
  always_comb begin
    rdData = 32'h0000_0000;
    hit    = 1'b0;
    case (addr)
      ADDR_KDATA: begin rdData = {28'h000_0000, kData}; hit = 1'b1; end
      ADDR_SDATA: begin rdData = {22'h00_0000, sData};  hit = 1'b1; end
      ADDR_KCTRL: begin rdData = {23'h00_0000, kIe, 5'h00, kOvr, 1'b0, kReady}; hit = 1'b1; end
      ADDR_SCTRL: begin rdData = {23'h00_0000, sIe, 5'h00, sOvr, 1'b0, sReady}; hit = 1'b1; end
      default:    begin rdData = 32'h0000_0000; hit = 1'b0; end
    endcase
  end
endmodule

// File: doc/key_sw_io_device.md
Name: key_sw_io_device

Overview:
- Memory-mapped input responder on the processor's data bus; the input-side counterpart to the LED/HEX output path.
- Synchronizes and debounces the raw KEY[3:0] and SW[9:0] board inputs.
- Latches debounced values into data registers and raises per-device ready/overrun status and interrupt requests.
- Answers processor loads and stores at fixed I/O addresses; sits beside data memory inside the memory stage.

Parameters:
ADDR_KDATA, 32'hF0000010, KEY data register address (read-only)
ADDR_SDATA, 32'hF0000014, SW data register address (read-only)
ADDR_KCTRL, 32'hF0000110, KEY control/status register address
ADDR_SCTRL, 32'hF0000114, SW control/status register address
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required to accept a new input value (>=1)
CNT_BITS, 16, debounce counter width; must hold DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
addr  input  32  byte address of the current memory-stage access
wrData  input  32  store data
isLoad  input  1  load strobe, valid for the current cycle
isStore  input  1  store strobe, valid for the current cycle
KEY  input  4  raw pushbuttons, active-low (0 = pressed)
SW  input  10  raw switches
rdData  output  32  read data, valid in the same cycle as addr
hit  output  1  addr matches one of the four registers
kIntr  output  1  KEY interrupt request
sIntr  output  1  SW interrupt request

Behaviour:
- Reset (reset = 0, asynchronous):
  - Synchronizers and debounce counters clear.
  - KDATA = 0 and SDATA = 0.
  - All ctrl bits clear.
  - kIntr = sIntr = 0.
- Input conditioning:
  - Two-flop synchronizer per input bit.
  - KEY is inverted after synchronization, so KDATA bit = 1 means the button is pressed.
- Debounce, per device (KEY, SW) over the whole device vector:
  - The counter resets to 0 whenever the synchronized vector differs from the previous-cycle sample.
  - Otherwise the counter increments, saturating at DEBOUNCE_CYCLES.
  - When the counter reaches DEBOUNCE_CYCLES and the sample differs from the data register, the data register loads the sample on that edge. This is a "change event".
  - Latency from a stable input to the register update = 2 sync + DEBOUNCE_CYCLES + 1 cycles.
- Ctrl register layout (identical for KEY and SW):
  - bit0 ready: set by a change event.
  - bit2 overrun: set by a change event while ready is already 1 and is not being cleared in the same cycle.
  - bit8 IE.
  - All other bits read 0.
- Reads:
  - rdData is combinational. Data registers are zero-extended; ctrl reads return the layout above.
  - For a non-hit address, rdData = 0 and hit = 0.
  - A load of KDATA or SDATA (isLoad = 1) clears that device's ready at the clock edge.
- Writes:
  - Stores to the data registers are ignored.
  - A store to a ctrl register writes IE = wrData[8].
  - A store with wrData[0] = 0 clears ready; wrData[0] = 1 leaves ready unchanged. Software cannot set ready.
  - A store with wrData[2] = 0 clears overrun; wrData[2] = 1 leaves overrun unchanged.
- Simultaneous events:
  - A change event in the same cycle as a ready-clearing load or store: the event wins, ready = 1, overrun unchanged.
  - isLoad and isStore both asserted is illegal; the store takes priority.
- Interrupts:
  - kIntr = KCTRL.ready & KCTRL.IE, registered, so it asserts one cycle after the enabling condition.
  - sIntr follows the same rule for SW.
- Reset asserted mid-debounce: everything clears immediately. After release, the current inputs are re-qualified from count 0. A non-zero stable input produces a change event (data differs from 0).

Test Plan:
- Reset, all KEY = 4'hF, SW = 0, DEBOUNCE_CYCLES = 4 -> after 20 cycles KDATA = 0, KCTRL = 0, no interrupts, load of ADDR_KDATA returns 0, hit = 1.
- KEY = 4'b1110 held stable -> KDATA = 32'h1 and KCTRL = 32'h1 exactly 7 cycles after the change; a load of KDATA then reads 32'h1 and KCTRL reads 0 on the next cycle.
- SW toggles bit3 every 2 cycles for 20 cycles, then holds 10'h008 -> SDATA stays 0 during toggling and becomes 32'h8 only after 4 stable samples.
- Two SW change events with no intervening read -> SCTRL = 32'h5; store 32'h0 to ADDR_SCTRL -> SCTRL = 0.
- Store 32'h100 to ADDR_KCTRL, then press KEY[2] -> kIntr rises one cycle after ready; a load of KDATA drops kIntr on the following cycle.
- Change event in the same cycle as a KDATA load -> ready remains 1; store to ADDR_KDATA changes nothing; load at 32'hF0000018 -> hit = 0, rdData = 0.
